// File: rtl/jk_reg_bank.sv
// Prescaled bank of JK flip-flops with up/down/hold counter modes and terminal-count flag.
// Optional JK_REG_BANK_LOAD_EN adds a parallel load (iLoad/iData) applied at the update edge.
module jk_reg_bank #(
    parameter int OLD_HZ = 10,
    parameter int NEW_HZ = 1,
    parameter int WIDTH  = 4
) (
    input  logic             iClk,
    input  logic             iReset,
    input  logic [WIDTH-1:0] iJ,
    input  logic [WIDTH-1:0] iK,
    input  logic [1:0]       iMode,
`ifdef JK_REG_BANK_LOAD_EN
    input  logic             iLoad,
    input  logic [WIDTH-1:0] iData,
`endif
    output logic [WIDTH-1:0] oQ,
    output logic [WIDTH-1:0] oQ_bar,
    output logic             oclk_div,
    output logic             oTick,
    output logic             oTC
);

    localparam int DIV = OLD_HZ / NEW_HZ;
    localparam int PW  = (DIV > 2) ? $clog2(DIV) : 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
    localparam logic [PW-1:0] PRESC_HALF = PW'(DIV / 2);

    localparam logic [1:0] MODE_BANK = 2'b00;
    localparam logic [1:0] MODE_UP   = 2'b01;
    localparam logic [1:0] MODE_DOWN = 2'b10;
    localparam logic [1:0] MODE_HOLD = 2'b11;

    generate
        if (NEW_HZ < 1 || WIDTH < 1) begin : g_bad_param
            $error("jk_reg_bank: NEW_HZ and WIDTH must be at least 1");
        end else if ((OLD_HZ % NEW_HZ) != 0 || DIV < 2) begin : g_bad_div
            $error("jk_reg_bank: OLD_HZ must be a multiple of NEW_HZ with a ratio of at least 2");
        end
    endgenerate

    logic [PW-1:0]    presc;
    logic [PW-1:0]    presc_next;
    logic             tick;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] q_mode;
    logic [WIDTH-1:0] q_next;

    assign tick = (presc == PRESC_LAST);

    always_comb begin
        presc_next = presc + PW'(1);
        if (tick) begin
            presc_next = '0;
        end
    end

    // Per-bit JK characteristic: set on J, clear on K, toggle on both.
    always_comb begin
        q_mode = q;
        case (iMode)
            MODE_BANK: q_mode = (~q & iJ) | (q & ~iK);
            MODE_UP:   q_mode = q + WIDTH'(1);
            MODE_DOWN: q_mode = q - WIDTH'(1);
            MODE_HOLD: q_mode = q;
            default:   q_mode = q;
        endcase
    end

    always_comb begin
        q_next = q_mode;
`ifdef JK_REG_BANK_LOAD_EN
        if (iLoad) begin
            q_next = iData;
        end
`endif
    end

    // Mode/load are only sampled on the wrap edge, so mid-interval changes wait for the next tick.
    always_ff @(posedge iClk) begin
        if (iReset) begin
            presc <= '0;
            q     <= '0;
        end else begin
            presc <= presc_next;
            if (tick) begin
                q <= q_next;
            end
        end
    end

    assign oQ       = q;
    assign oQ_bar   = ~q;
    assign oTick    = tick;
    assign oclk_div = (presc >= PRESC_HALF);
    assign oTC      = ((iMode == MODE_UP)   && (&q)) ||
                      ((iMode == MODE_DOWN) && (~|q));

endmodule

// File: tb/tb_jk_reg_bank.sv
// Scoreboard bench for jk_reg_bank at WIDTH=4, DIV=10; load tests compile in with JK_REG_BANK_LOAD_EN.
module tb_jk_reg_bank;

    logic       iClk   = 1'b0;
    logic       iReset = 1'b1;
    logic [3:0] iJ     = 4'h0;
    logic [3:0] iK     = 4'h0;
    logic [1:0] iMode  = 2'b00;
`ifdef JK_REG_BANK_LOAD_EN
    logic       iLoad  = 1'b0;
    logic [3:0] iData  = 4'h0;
`endif
    logic [3:0] oQ;
    logic [3:0] oQ_bar;
    logic       oclk_div;
    logic       oTick;
    logic       oTC;

    int errors = 0;
    int checks = 0;
    logic [3:0] exp_q[$];
    logic [3:0] cur_q;

    jk_reg_bank #(.OLD_HZ(10), .NEW_HZ(1), .WIDTH(4)) dut (
        .iClk    (iClk),
        .iReset  (iReset),
        .iJ      (iJ),
        .iK      (iK),
        .iMode   (iMode),
`ifdef JK_REG_BANK_LOAD_EN
        .iLoad   (iLoad),
        .iData   (iData),
`endif
        .oQ      (oQ),
        .oQ_bar  (oQ_bar),
        .oclk_div(oclk_div),
        .oTick   (oTick),
        .oTC     (oTC)
    );

    always #5 iClk = ~iClk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge iClk);
        #1;
    endtask

    // Waits for oTick (expecting it after exp_wait cycles), takes the update edge, pops and compares.
    task automatic run_tick(input int exp_wait);
        int n = 0;
        logic [3:0] e;
        while (oTick !== 1'b1 && n < 20) begin
            checks++;
            if (oQ !== cur_q || oQ_bar !== ~cur_q) begin
                errors++;
                $display("FAIL hold_between_ticks: oQ=%b oQ_bar=%b required oQ=%b", oQ, oQ_bar, cur_q);
            end
            step();
            n++;
        end
        checks++;
        if (n !== exp_wait) begin
            errors++;
            $display("FAIL tick_spacing: waited %0d cycles required %0d", n, exp_wait);
        end
        step();
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty: no expected value queued");
            e = cur_q;
        end else begin
            e = exp_q.pop_front();
        end
        checks++;
        if (oQ !== e) begin
            errors++;
            $display("FAIL tick_update: oQ=%b required %b", oQ, e);
        end
        checks++;
        if (oQ_bar !== ~e) begin
            errors++;
            $display("FAIL tick_qbar: oQ_bar=%b required %b", oQ_bar, ~e);
        end
        checks++;
        if (oTick !== 1'b0) begin
            errors++;
            $display("FAIL tick_width: oTick=%b required 0", oTick);
        end
        cur_q = e;
    endtask

    task automatic set_q(input logic [3:0] v);
        iMode = 2'b00;
        iJ    = v;
        iK    = ~v;
        exp_q.push_back(v);
        run_tick(9);
        iJ = 4'h0;
        iK = 4'h0;
    endtask

    task automatic test_reset();
        int cyc;
        iReset = 1'b1;
        for (int i = 0; i < 17; i++) begin
            step();
            checks++;
            if (oQ !== 4'b0000 || oQ_bar !== 4'b1111 || oclk_div !== 1'b0 || oTick !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold: oQ=%b oQ_bar=%b clk_div=%b tick=%b required 0000 1111 0 0",
                         oQ, oQ_bar, oclk_div, oTick);
            end
        end
        iReset = 1'b0;
        cur_q  = 4'b0000;
        cyc    = 1;
        while (oTick !== 1'b1 && cyc < 20) begin
            checks++;
            if (oQ !== 4'b0000) begin
                errors++;
                $display("FAIL reset_release_q: oQ=%b required 0000", oQ);
            end
            step();
            cyc++;
        end
        checks++;
        if (cyc !== 10) begin
            errors++;
            $display("FAIL first_tick: oTick in cycle %0d required 10", cyc);
        end
        step();
        checks++;
        if (oQ !== 4'b0000 || oTick !== 1'b0) begin
            errors++;
            $display("FAIL first_tick_idle: oQ=%b tick=%b required 0000 0", oQ, oTick);
        end
    endtask

    task automatic test_bank();
        iMode = 2'b00;
        iJ    = 4'b0101;
        iK    = 4'b0011;
        exp_q.push_back(4'b0101);
        exp_q.push_back(4'b0100);
        run_tick(9);
        run_tick(9);
        iJ = 4'h0;
        iK = 4'h0;
    endtask

    task automatic test_up_down();
        set_q(4'b1110);
        iMode = 2'b01;
        checks++;
        if (oTC !== 1'b0) begin
            errors++;
            $display("FAIL tc_up_1110: oTC=%b required 0", oTC);
        end
        iJ = 4'b1010;
        iK = 4'b0110;
        exp_q.push_back(4'b1111);
        run_tick(9);
        checks++;
        if (oTC !== 1'b1) begin
            errors++;
            $display("FAIL tc_up_1111: oTC=%b required 1", oTC);
        end
        iMode = 2'b10;
        #1;
        checks++;
        if (oTC !== 1'b0) begin
            errors++;
            $display("FAIL tc_down_1111: oTC=%b required 0", oTC);
        end
        iMode = 2'b01;
        exp_q.push_back(4'b0000);
        run_tick(9);
        checks++;
        if (oTC !== 1'b0) begin
            errors++;
            $display("FAIL tc_up_wrap: oTC=%b required 0", oTC);
        end
        exp_q.push_back(4'b0001);
        run_tick(9);
        iMode = 2'b10;
        exp_q.push_back(4'b0000);
        run_tick(9);
        checks++;
        if (oTC !== 1'b1) begin
            errors++;
            $display("FAIL tc_down_0000: oTC=%b required 1", oTC);
        end
        exp_q.push_back(4'b1111);
        run_tick(9);
        checks++;
        if (oTC !== 1'b0) begin
            errors++;
            $display("FAIL tc_down_wrap: oTC=%b required 0", oTC);
        end
        iJ = 4'h0;
        iK = 4'h0;
    endtask

    task automatic test_reset_mid();
        set_q(4'b0111);
        iMode = 2'b11;
        repeat (6) step();
        iReset = 1'b1;
        step();
        iReset = 1'b0;
        cur_q  = 4'b0000;
        checks++;
        if (oQ !== 4'b0000 || oQ_bar !== 4'b1111 || oTick !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: oQ=%b oQ_bar=%b tick=%b required 0000 1111 0", oQ, oQ_bar, oTick);
        end
        for (int cyc = 1; cyc <= 10; cyc++) begin
            checks++;
            if (oclk_div !== (cyc > 5) || oTick !== (cyc == 10)) begin
                errors++;
                $display("FAIL reset_mid_phase: cycle %0d clk_div=%b tick=%b required %b %b",
                         cyc, oclk_div, oTick, (cyc > 5), (cyc == 10));
            end
            step();
        end
        checks++;
        if (oQ !== 4'b0000 || oclk_div !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_after: oQ=%b clk_div=%b required 0000 0", oQ, oclk_div);
        end
    endtask

    task automatic test_hold();
        set_q(4'b1001);
        iMode = 2'b11;
        iJ    = 4'b1111;
        iK    = 4'b1111;
        repeat (3) begin
            exp_q.push_back(4'b1001);
            run_tick(9);
        end
        iJ = 4'h0;
        iK = 4'h0;
    endtask

    task automatic test_mode_change();
        iMode = 2'b01;
        exp_q.push_back(4'b1000);
        repeat (4) begin
            step();
            checks++;
            if (oQ !== cur_q) begin
                errors++;
                $display("FAIL mode_change_early: oQ=%b required %b", oQ, cur_q);
            end
        end
        iMode = 2'b10;
        run_tick(5);
    endtask

    task automatic test_back_to_back();
        iMode = 2'b01;
        exp_q.push_back(4'b1001);
        exp_q.push_back(4'b1010);
        exp_q.push_back(4'b1011);
        run_tick(9);
        run_tick(9);
        run_tick(9);
    endtask

`ifdef JK_REG_BANK_LOAD_EN
    task automatic test_load();
        iMode = 2'b01;
        iLoad = 1'b1;
        iData = 4'b1010;
        exp_q.push_back(4'b1010);
        run_tick(9);
        iLoad = 1'b0;
        exp_q.push_back(4'b1011);
        run_tick(9);
        iLoad  = 1'b1;
        iData  = 4'b0110;
        repeat (9) step();
        iReset = 1'b1;
        step();
        iReset = 1'b0;
        iLoad  = 1'b0;
        cur_q  = 4'b0000;
        checks++;
        if (oQ !== 4'b0000) begin
            errors++;
            $display("FAIL load_reset: oQ=%b required 0000", oQ);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_bank();
        test_up_down();
        test_reset_mid();
        test_hold();
        test_mode_change();
        test_back_to_back();
`ifdef JK_REG_BANK_LOAD_EN
        test_load();
`endif
        checks++;
        if (exp_q.size() !== 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: %0d entries left required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/jk_reg_bank.md
JK_REG_BANK -- requirements
Module: jk_reg_bank

Interface
REQ-001 Parameter OLD_HZ, default 10, input clock rate in Hz.
REQ-002 Parameter NEW_HZ, default 1, update rate in Hz; DIV = OLD_HZ/NEW_HZ; OLD_HZ divisible by NEW_HZ and DIV >= 2 SHALL hold at elaboration.
REQ-003 Parameter WIDTH, default 4, number of JK bits; WIDTH >= 1.
REQ-004 iClk  input  1  sole clock; all state updates on rising edge.
REQ-005 iReset  input  1  synchronous, active-high reset.
REQ-006 iJ  input  WIDTH  per-bit J inputs.
REQ-007 iK  input  WIDTH  per-bit K inputs.
REQ-008 iMode  input  2  00 bank, 01 up-count, 10 down-count, 11 hold.
REQ-009 oQ  output  WIDTH  registered state.
REQ-010 oQ_bar  output  WIDTH  bitwise complement of oQ at all times.
REQ-011 oclk_div  output  1  divided clock, period DIV iClk cycles.
REQ-012 oTick  output  1  one-iClk-cycle pulse marking the update edge.
REQ-013 oTC  output  1  terminal-count flag.

Function
REQ-014 Prescaler SHALL count 0..DIV-1 and wrap to 0; oTick = 1 exactly while prescaler == DIV-1.
REQ-015 oQ SHALL change only on the iClk edge where oTick = 1 (prescaler wraps DIV-1 -> 0); inputs at other edges ignored.
REQ-016 oclk_div SHALL be 1 while prescaler >= DIV/2 (integer division) and 0 otherwise, so its falling edge coincides with the oQ update edge.
REQ-017 Bank mode (00), per bit i at update edge: J=0,K=0 hold; J=0,K=1 clear; J=1,K=0 set; J=1,K=1 toggle.
REQ-018 Up mode (01): oQ <= oQ + 1 mod 2^WIDTH; iJ/iK ignored.
REQ-019 Down mode (10): oQ <= oQ - 1 mod 2^WIDTH; iJ/iK ignored.
REQ-020 Hold mode (11): oQ unchanged; prescaler, oclk_div, oTick keep running.
REQ-021 oTC SHALL be combinational: 1 when iMode=01 and oQ all ones, or iMode=10 and oQ all zeros; 0 otherwise.
REQ-022 iMode change between ticks SHALL take effect at the next tick only; no partial update.
REQ-023 Wrap-around: up from all ones -> all zeros; down from all zeros -> all ones; no sticky flag.

Reset
REQ-024 While iReset = 1 at a rising edge: prescaler <= 0, oQ <= 0, hence oQ_bar = all ones, oclk_div = 0, oTick = 0.
REQ-025 Reset SHALL override tick, mode and load in the same cycle, including when asserted mid-count.
REQ-026 After release, first oTick SHALL occur DIV cycles after the last reset edge (prescaler restarts at 0).

Configuration
REQ-027 Macro JK_REG_BANK_LOAD_EN defined: ports iLoad (input, 1) and iData (input, WIDTH) SHALL exist; iLoad = 1 at an update edge sets oQ <= iData, priority over mode, below reset.
REQ-028 Macro undefined: iLoad/iData ports SHALL be absent; behaviour as REQ-014..REQ-026.

Verification (WIDTH=4, OLD_HZ=10, NEW_HZ=1, DIV=10)
REQ-029 iReset=1 for 17 cycles -> oQ=0000, oQ_bar=1111, oclk_div=0, oTick=0 throughout; first oTick 10 cycles after release.
REQ-030 Bank, oQ=0000, iJ=0101, iK=0011 -> oQ=0101 after first tick, 0100 after second; no change between ticks.
REQ-031 Up from 1110 -> 1111 with oTC=1, next tick 0000 with oTC=0; down from 0001 -> 0000 (oTC=1) -> 1111.
REQ-032 iReset pulsed 1 cycle at prescaler=6 with oQ=0111 -> oQ=0000 next edge; next oTick exactly 10 cycles later; oclk_div low 5 cycles then high 5.
REQ-033 Hold mode 3 ticks with oQ=1001 -> oQ stays 1001; oTick pulses each 10 cycles.
REQ-034 JK_REG_BANK_LOAD_EN: up mode, iLoad=1, iData=1010 at tick -> oQ=1010; iLoad=0 next tick -> 1011; iReset with iLoad -> 0000.
